// File: rtl/imm_gen_pkg.sv
// Shared constants and types for the pipelined immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  // Skid occupancy: number of valid entries held by the stage.
  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } occ_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational instruction-to-immediate decode, ISA-correct or legacy zero-extended.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          LEGACY_ZEXT = 1'b0,
  parameter int unsigned SHAMT_W     = 5
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [63:0] imm64;
  logic [2:0]  funct3;
  logic        unused_imm_hi;

  assign funct3 = instr_i[14:12];

  always_comb begin
    imm64     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    unique case (instr_i[6:0])
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm64 = LEGACY_ZEXT ? {52'b0, instr_i[31:20]} : {{52{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_o                 = FMT_SHAMT;
          imm64[SHAMT_W-1:0]    = instr_i[20 +: SHAMT_W];
        end else begin
          fmt_o = FMT_I;
          imm64 = LEGACY_ZEXT ? {52'b0, instr_i[31:20]}
                              : {{52{instr_i[31]}}, instr_i[31:20]};
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm64 = LEGACY_ZEXT ? {52'b0, instr_i[31:25], instr_i[11:7]}
                            : {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm64 = LEGACY_ZEXT
              ? {52'b0, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]}
              : {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm64 = LEGACY_ZEXT ? {44'b0, instr_i[31:12]}
                            : {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm64 = LEGACY_ZEXT
              ? {44'b0, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]}
              : {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // CSR address is an unsigned index; the legacy decoder never supported SYSTEM.
        if (LEGACY_ZEXT) begin
          illegal_o = 1'b1;
        end else begin
          fmt_o = FMT_I;
          imm64 = {52'b0, instr_i[31:20]};
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign imm_o         = imm64[XLEN-1:0];
  assign unused_imm_hi = ^imm64;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode on capture, 2-entry skid buffer, synchronous flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          LEGACY_ZEXT = 1'b0,
  parameter int unsigned SHAMT_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  input  logic            flush
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } entry_t;

  occ_e   state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   in_fire, out_fire;

  imm_decode_comb #(
    .XLEN        (XLEN),
    .LEGACY_ZEXT (LEGACY_ZEXT),
    .SHAMT_W     (SHAMT_W)
  ) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec.imm),
    .fmt_o     (dec.fmt),
    .illegal_o (dec.illegal)
  );

  // Handshake flags come straight from the state register, never from out_ready.
  assign out_valid   = (state_q != StEmpty);
  assign in_ready    = (state_q != StTwo);
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush beats every fire; payload registers are left untouched as they are don't-care.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: three configurations driven in lockstep against a queue-based model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        flush;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        rdyl, vl, illl;
  logic [31:0] imml;
  logic [2:0]  fmtl;

  int checks = 0;
  int errors = 0;
  int dut_pops = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .LEGACY_ZEXT(1'b0), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .flush(flush)
  );

  imm_gen_pipe #(.XLEN(64), .LEGACY_ZEXT(1'b0), .SHAMT_W(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .flush(flush)
  );

  imm_gen_pipe #(.XLEN(32), .LEGACY_ZEXT(1'b1), .SHAMT_W(5)) dutl (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyl), .in_instr(in_instr),
    .out_valid(vl), .out_ready(out_ready), .out_imm(imml), .out_fmt(fmtl),
    .out_illegal(illl), .flush(flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    longint half = longint'(1) << (w - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  // Immediate as a number, computed from the field arithmetic of each format.
  function automatic void model(input logic [31:0] w, input bit x64, input bit leg,
                                output logic [63:0] imm, output logic [2:0] fmt,
                                output logic ill);
    longint v  = 0;
    longint shw = x64 ? 6 : 5;
    longint fi = longint'(w[31:20]);
    longint fs = longint'(w[31:25]) * 32 + longint'(w[11:7]);
    longint fb = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
               + longint'(w[11:8]) * 2;
    longint fu = longint'(w[31:12]) * 4096;
    longint fj = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
               + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
    fmt = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h67: begin fmt = 3'd1; v = leg ? fi : sx(fi, 12); end
      7'h13: begin
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          fmt = 3'd6; v = fi % (longint'(1) << shw);
        end else begin
          fmt = 3'd1; v = leg ? fi : sx(fi, 12);
        end
      end
      7'h23: begin fmt = 3'd2; v = leg ? fs : sx(fs, 12); end
      7'h63: begin fmt = 3'd3; v = leg ? fb / 2 : sx(fb, 13); end
      7'h37, 7'h17: begin fmt = 3'd4; v = leg ? fu / 4096 : sx(fu, 32); end
      7'h6F: begin fmt = 3'd5; v = leg ? fj / 2 : sx(fj, 21); end
      7'h73: begin
        if (leg) ill = 1'b1;
        else begin fmt = 3'd1; v = fi; end
      end
      default: ill = 1'b1;
    endcase
    imm = v;
    if (!x64) imm[63:32] = '0;
  endfunction

  // One clock: drive, check at negedge against the model, then advance the model.
  task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    logic [63:0] ei; logic [2:0] ef; logic eil;
    bit ifire, ofire;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid64", v64, q.size() > 0);
    chk("out_valid_leg", vl, q.size() > 0);
    if (q.size() > 0) begin
      model(q[0], 1'b0, 1'b0, ei, ef, eil);
      chk("imm32", out_imm, ei); chk("fmt32", out_fmt, ef); chk("ill32", out_illegal, eil);
      model(q[0], 1'b1, 1'b0, ei, ef, eil);
      chk("imm64", imm64, ei); chk("fmt64", fmt64, ef); chk("ill64", ill64, eil);
      model(q[0], 1'b0, 1'b1, ei, ef, eil);
      chk("imm_leg", imml, ei); chk("fmt_leg", fmtl, ef); chk("ill_leg", illl, eil);
    end
    if (out_valid && out_ready) dut_pops++;
    ifire = v && (q.size() < 2);
    ofire = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(ins);
    end
    #1;
  endtask

  // Freeze the stage one cycle and compare the head against literal expectations.
  task automatic peek(input string tag, input logic [63:0] e32, input logic [2:0] ef,
                      input logic [63:0] e64, input logic [63:0] eleg, input logic eill);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_imm32"}, out_imm, e32);
    chk({tag, "_fmt"}, out_fmt, ef);
    chk({tag, "_ill"}, out_illegal, eill);
    chk({tag, "_imm64"}, imm64, e64);
    chk({tag, "_imm_leg"}, imml, eleg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bp[4];
    logic [6:0]  opcs[10];
    logic [31:0] r, w;
    int sent, pops0;

    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_fmt", out_fmt, 3'd0);
    chk("rst_out_ill", out_illegal, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Directed words with literal expected values for all three configurations.
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    peek("addi", 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 32'h00000FFF, 1'b0);
    cycle(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    peek("beq", 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 32'h00000FFE, 1'b0);
    cycle(1'b1, 32'h123450B7, 1'b1, 1'b0);
    peek("lui", 32'h12345000, 3'd4, 64'h0000000012345000, 32'h00012345, 1'b0);
    cycle(1'b1, 32'h00309093, 1'b1, 1'b0);
    peek("slli", 32'h3, 3'd6, 64'h3, 32'h3, 1'b0);
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    peek("opc7f", 32'h0, 3'd0, 64'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'hFFFFF06F, 1'b1, 1'b0);
    peek("jal", 32'hFFFFFFFE, 3'd5, 64'hFFFFFFFFFFFFFFFE, 32'h000FFFFF, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: four instructions against a stalled consumer, then release.
    bp[0] = 32'h00A00513; bp[1] = 32'hFEB12E23; bp[2] = 32'h008000EF; bp[3] = 32'h80000437;
    sent = 0;
    pops0 = dut_pops;
    for (int c = 0; c < 30 && (sent < 4 || q.size() > 0); c++) begin
      bit acc;
      acc = (sent < 4) && (q.size() < 2);
      w = (sent < 4) ? bp[sent] : 32'h0;
      if (c == 3) chk("bp_stall_in_ready", in_ready, 1'b0);
      cycle(sent < 4, w, c >= 6, 1'b0);
      if (acc) sent++;
    end
    chk("bp_out_count", dut_pops - pops0, 4);

    // Flush with both entries held and a new input presented.
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
    cycle(1'b1, 32'h7FF00013, 1'b0, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    pops0 = dut_pops;
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_output", dut_pops - pops0, 0);

    // Randomized traffic with occasional flush.
    opcs = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B};
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      w = {r[31:7], opcs[$urandom_range(0, 9)]};
      if ($urandom_range(0, 15) == 0) w[6:0] = r[6:0];
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    // Reset mid-stream with the buffer full and an input still offered.
    cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 1'b0, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #2;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_imm", out_imm, 32'h0);
    chk("midrst_out_fmt", out_fmt, 3'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pops0 = dut_pops;
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("midrst_no_stale", dut_pops - pops0, 0);
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It accepts one 32-bit RV32I/RV64I instruction per cycle over a valid/ready handshake and returns the architecturally correct immediate one cycle later: sign-extended, with B/J/U scaling applied. It also reports the instruction format and an unsupported-opcode flag. The block sits between fetch/decode and execute, and a 2-entry skid buffer provides full throughput under back-pressure.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64.
LEGACY_ZEXT, 0, 1 selects the old zero-extended, unscaled encoding for bring-up comparison; 0 selects ISA-correct output.
SHAMT_W, 5, shift-amount width; set to 6 when XLEN=64.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  instruction present
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
out_valid  out  1  result present
out_ready  in  1  consumer accepts
out_imm  out  XLEN  generated immediate
out_fmt  out  3  format code (see package)
out_illegal  out  1  opcode not in supported set
flush  in  1  synchronous kill of all buffered entries

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_illegal=0.
  - Both skid entries are invalidated; in_ready=1 on the first cycle after release.
- Transfer rules: input fires when in_valid & in_ready; output fires when out_valid & out_ready.
- Latency and throughput: 1 cycle from input fire to out_valid; sustained 1 result per cycle while out_ready=1.
- Buffering: 2-entry skid (main + skid register). in_ready = ~skid_valid, registered and not combinationally dependent on out_ready.
- State machine (occupancy):
  - EMPTY: in fire -> ONE.
  - ONE: in fire & ~out fire -> TWO; out fire & ~in fire -> EMPTY; both -> ONE.
  - TWO: in_ready=0; out fire -> ONE.
- Ordering: strict FIFO; results leave in input order.
- Decode is combinational on in_instr and registered on capture; out_* is stable while out_valid & ~out_ready.
- Opcode map (ISA mode):
  - 0x03, 0x67: I-type, sext(inst[31:20]).
  - 0x13: I-type; if funct3 is 001 or 101, SHAMT type, zext(inst[20+SHAMT_W-1:20]).
  - 0x23: S-type, sext({inst[31:25], inst[11:7]}).
  - 0x63: B-type, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0x37, 0x17: U-type, sext({inst[31:12], 12'b0}).
  - 0x6F: J-type, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0x73: I-type, zext(inst[31:20]) (CSR address).
  - Any other opcode: out_imm=0, out_fmt=FMT_NONE, out_illegal=1.
- Legacy mode (LEGACY_ZEXT=1):
  - Same bit selections without the 1'b0 or 12'b0 scaling.
  - All values zero-extended to XLEN.
  - Opcode 0x73 is illegal.
- Flush:
  - Clears both entries next edge; out_valid=0 and in_ready=1 the following cycle.
  - An input presented in the same cycle as flush is dropped.
  - Flush has priority over all fires.
- Reset mid-transfer: all in-flight entries are discarded with no partial output.

Decomposition:
- imm_gen_pkg holds:
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM.
  - Format enum (3 bits): FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SHAMT=6.
- Sub-module imm_decode_comb: pure combinational instruction-to-{imm, fmt, illegal}, parametrised on XLEN, LEGACY_ZEXT and SHAMT_W.
- The top level contains only the skid buffer, occupancy FSM and flush logic.

Test Plan:
- Reset: hold rst_n=0 mid-stream with in_valid=1 -> out_valid=0 and out_imm=0 during reset; no stale output after release.
- Sign extension (XLEN=32, ISA mode): addi 0xFFF00093 -> out_imm=0xFFFFFFFF, fmt=FMT_I; beq -4 0xFE000EE3 -> 0xFFFFFFFC, fmt=FMT_B; lui 0x123450B7 -> 0x12345000, fmt=FMT_U.
- Shift and illegal opcodes: slli 0x00309093 -> out_imm=3, fmt=FMT_SHAMT; opcode 0x7F word 0x0000007F -> out_illegal=1, out_imm=0.
- Back-pressure: stream 4 back-to-back instructions with out_ready=0 -> in_ready drops after 2 accepts; release out_ready -> all 4 emerge in order with no loss or duplication.
- Flush with buffer full (TWO) and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears at the output.
- Configuration variants: XLEN=64, SHAMT_W=6, jal -2 encoding 0xFFFFF06F -> 0xFFFFFFFFFFFFFFFE; same word with LEGACY_ZEXT=1, XLEN=32 -> 0x000FFFFF.
